intr_prio_enc: RTL and testbench

INTR_PRIO_ENC -- requirements
Module: intr_prio_enc

---
 rtl/intr_prio_pkg.sv | 17 +
 rtl/intr_prio_enc_sel.sv | 26 ++
 rtl/intr_prio_enc.sv | 85 ++++++++
 tb/tb_intr_prio_enc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/intr_prio_pkg.sv
// Shared constants, FSM state encoding and index helper for the interrupt priority encoder.
package intr_prio_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Index reached by stepping 'off' places down from p, wrapping modulo N_REQ.
    function automatic logic [CODE_W-1:0] rotIdx(input logic [CODE_W-1:0] p, input int off);
        return p - CODE_W'(off);
    endfunction

endpackage

// File: rtl/intr_prio_enc_sel.sv
// Combinational priority selector: searches cand starting at index p and walking downward.
// With p held at N_REQ-1 this is the plain highest-index-wins encoder.
module prio_sel #(
    parameter int N_REQ  = intr_prio_pkg::N_REQ,
    parameter int CODE_W = intr_prio_pkg::CODE_W
) (
    input  logic [N_REQ-1:0]  cand,
    input  logic [CODE_W-1:0] p,
    output logic [CODE_W-1:0] index,
    output logic              found
);
    import intr_prio_pkg::*;

    // Walk from lowest to highest priority so the last hit (offset 0) wins.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[rotIdx(p, i)]) begin
                index = rotIdx(p, i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_prio_enc.sv
// Interrupt priority encoder with sticky pending set and valid/ready output handshake.
// Define INTR_PRIO_ENC_RR_EN for rotating priority; otherwise fixed priority (3 > 2 > 1 > 0).
module intr_prio_enc #(
    parameter int N_REQ  = intr_prio_pkg::N_REQ,
    parameter int CODE_W = intr_prio_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] y,
    output logic              valid,
    input  logic              ready,
    output logic [N_REQ-1:0]  pend
);
    import intr_prio_pkg::*;

    state_t             r_state;
    logic [CODE_W-1:0]  r_y;
    logic               r_valid;
    logic [N_REQ-1:0]   r_pend;

    logic [N_REQ-1:0]   w_cand;
    logic [CODE_W-1:0]  w_idx;
    logic [CODE_W-1:0]  w_ptr;
    logic               w_found;
    logic               w_issue;

    assign w_cand  = r_pend | req;
    assign w_issue = (r_state == EMPTY) || ready;

    prio_sel #(
        .N_REQ  (N_REQ),
        .CODE_W (CODE_W)
    ) u_sel (
        .cand  (w_cand),
        .p     (w_ptr),
        .index (w_idx),
        .found (w_found)
    );

`ifdef INTR_PRIO_ENC_RR_EN
    logic [CODE_W-1:0] r_ptr;

    // After issuing k the search starts just below k, so k becomes lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= CODE_W'(N_REQ - 1);
        end else if (w_issue && w_found) begin
            r_ptr <= w_idx - CODE_W'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = CODE_W'(N_REQ - 1);
`endif

    // An issue cycle consumes the selected bit of cand; otherwise new requests just accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_y     <= '0;
            r_pend  <= '0;
        end else if (w_issue) begin
            if (w_found) begin
                r_state <= HOLD;
                r_valid <= 1'b1;
                r_y     <= w_idx;
                r_pend  <= w_cand & ~(N_REQ'(1) << w_idx);
            end else begin
                r_state <= EMPTY;
                r_valid <= 1'b0;
                r_pend  <= '0;
            end
        end else begin
            r_pend <= w_cand;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;
    assign pend  = r_pend;

endmodule

// File: tb/tb_intr_prio_enc.sv
// Self-checking bench for intr_prio_enc: directed scenarios plus randomized traffic
// compared against a behavioural model of the pending set and issue order.
module tb_intr_prio_enc;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] y;
    logic       valid;
    logic       ready;
    logic [3:0] pend;

    int total = 0;
    int bad   = 0;

    logic       mValid;
    int         mY;
    logic [3:0] mPend;
    int         mPtr;

    intr_prio_enc #(.N_REQ(4), .CODE_W(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .y     (y),
        .valid (valid),
        .ready (ready),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Search order starts at p and walks downward modulo 4.
    function automatic int pickIdx(input logic [3:0] c, input int p);
        for (int o = 0; o < 4; o++) begin
            int k;
            k = (p - o + 4) % 4;
            if (c[k]) return k;
        end
        return -1;
    endfunction

    task automatic modelEdge(input logic r, input logic [3:0] rq, input logic rd);
        logic [3:0] c;
        int k;
        if (r) begin
            mValid = 1'b0;
            mY     = 0;
            mPend  = 4'b0;
            mPtr   = 3;
        end else begin
            c = mPend | rq;
            if (!mValid || rd) begin
                k = pickIdx(c, mPtr);
                if (k >= 0) begin
                    mValid = 1'b1;
                    mY     = k;
                    mPend  = c & ~(4'b0001 << k);
`ifdef INTR_PRIO_ENC_RR_EN
                    mPtr   = (k + 3) % 4;
`endif
                end else begin
                    mValid = 1'b0;
                    mPend  = 4'b0;
                end
            end else begin
                mPend = c;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rd);
        rst   = r;
        req   = rq;
        ready = rd;
        @(posedge clk);
        modelEdge(r, rq, rd);
        #1;
        checkOutput("valid", {3'b0, valid}, {3'b0, mValid});
        checkOutput("pend", pend, mPend);
        if (mValid || r) checkOutput("y", {2'b0, y}, 4'(mY));
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; ready = 1'b0;
        mValid = 1'b0; mY = 0; mPend = 4'b0; mPtr = 3;

        // Reset state, with a request present that must be ignored.
        applyStimulus(1'b1, 4'b1111, 1'b1);
        checkOutput("rst_valid", {3'b0, valid}, 4'd0);
        checkOutput("rst_y", {2'b0, y}, 4'd0);
        checkOutput("rst_pend", pend, 4'd0);

        // Single pulse, one-cycle latency.
        applyStimulus(1'b0, 4'b0100, 1'b1);
        checkOutput("single_y", {2'b0, y}, 4'd2);
        checkOutput("single_valid", {3'b0, valid}, 4'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("single_idle", {3'b0, valid}, 4'd0);

        // Multiple requests drained back-to-back.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b1011, 1'b1);
        checkOutput("b2b_y0", {2'b0, y}, 4'd3);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_y1", {2'b0, y}, 4'd1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_y2", {2'b0, y}, 4'd0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("b2b_valid", {3'b0, valid}, 4'd0);
        checkOutput("b2b_pend", pend, 4'd0);

        // Output held stable under backpressure.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("hold_y0", {2'b0, y}, 4'd0);
        applyStimulus(1'b0, 4'b1000, 1'b0);
        checkOutput("hold_y1", {2'b0, y}, 4'd0);
        checkOutput("hold_pend", pend, 4'b1000);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("hold_y2", {2'b0, y}, 4'd3);
        applyStimulus(1'b0, 4'b0000, 1'b1);

        // Re-request of the index currently held.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("rereq_y", {2'b0, y}, 4'd2);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("rereq_pend", pend, 4'b0100);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("rereq_y2", {2'b0, y}, 4'd2);
        checkOutput("rereq_valid", {3'b0, valid}, 4'd1);
        checkOutput("rereq_pend2", pend, 4'd0);
        applyStimulus(1'b0, 4'b0000, 1'b1);

        // Request coinciding with its own issue is consumed.
        applyStimulus(1'b0, 4'b0010, 1'b1);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("coinc_y", {2'b0, y}, 4'd1);
        checkOutput("coinc_pend", pend, 4'd0);
        applyStimulus(1'b0, 4'b0000, 1'b1);

        // Reset in HOLD discards held and pending requests.
        applyStimulus(1'b0, 4'b1000, 1'b0);
        applyStimulus(1'b0, 4'b0110, 1'b0);
        checkOutput("mid_pend", pend, 4'b0110);
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("mid_valid", {3'b0, valid}, 4'd0);
        checkOutput("mid_pend2", pend, 4'd0);
        checkOutput("mid_y", {2'b0, y}, 4'd0);

`ifdef INTR_PRIO_ENC_RR_EN
        // Rotating priority visits every index.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_y0", {2'b0, y}, 4'd3);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_y1", {2'b0, y}, 4'd2);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_y2", {2'b0, y}, 4'd1);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_y3", {2'b0, y}, 4'd0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("rr_y4", {2'b0, y}, 4'd3);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic       r;
            logic [3:0] rq;
            logic       rd;
            r  = ($urandom_range(0, 59) == 0);
            rq = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rd = 1'($urandom_range(0, 1));
            applyStimulus(r, rq, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
